// File: rtl/piano_pkg.sv
// piano_pkg: constants and types shared between the key-to-frequency stage
// and the tone generator.
//   NUM_OF_NOTES : number of keyboard keys, one tone voice per key
//   FREQ_W       : width of a half-period word, in clk cycles
//   freq_t       : one half-period word
//   note_arr_t   : one half-period word per key
package piano_pkg;

  localparam int NUM_OF_NOTES = 13;
  localparam int FREQ_W       = 32;

  typedef logic [FREQ_W-1:0] freq_t;
  typedef freq_t note_arr_t [NUM_OF_NOTES-1:0];

endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice.
// Ports:
//   clk     : system clock
//   reset_n : asynchronous active-low reset, clears every register
//   hp_in   : requested half-period in clk cycles; 0 silences the voice
//   wave    : registered square wave (the voice phase)
//   active  : registered half-period is nonzero
// The half-period is registered here, so the voice responds one clock after
// hp_in changes. No valid/ready: hp_in is sampled on every clock edge.
module tone_voice
  import piano_pkg::*;
#(
  parameter int HP_W = FREQ_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [HP_W-1:0] hp_in,
  output logic            wave,
  output logic            active
);

  logic [HP_W-1:0] hp_q;
  logic [HP_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hp_q <= '0;
      cnt  <= '0;
      wave <= 1'b0;
    end else begin
      hp_q <= hp_in;
      if (hp_q == '0) begin
        // Silent voice parks at phase 0 / count 0 so the next press starts
        // a clean half-period; this wins over a toggle due this cycle.
        cnt  <= '0;
        wave <= 1'b0;
      end else if (cnt >= hp_q - HP_W'(1)) begin
        // '>=' lets a half-period that shrank below cnt wrap immediately.
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + HP_W'(1);
      end
    end
  end

  assign active = (hp_q != '0);

endmodule

// File: rtl/tone_generator.sv
// tone_generator: NUM_VOICES independent square-wave voices mixed into a
// 0..NUM_VOICES level, which drives a single-pin PWM DAC.
// Ports:
//   clk           : system clock (50 MHz)
//   reset_n       : asynchronous active-low reset, clears all state
//   noteFrequency : per-voice half-period in clk cycles; 0 = voice silent
//   voice_wave    : per-voice registered square wave
//   mix_level     : registered count of voices currently high
//   pwm_out       : PWM-encoded mix, period NUM_VOICES clocks
//   any_active    : any registered half-period is nonzero
module tone_generator #(
  parameter int NUM_VOICES = piano_pkg::NUM_OF_NOTES,
  parameter int FREQ_W     = piano_pkg::FREQ_W,
  parameter int LVL_W      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [FREQ_W-1:0]     noteFrequency [NUM_VOICES],
  output logic [NUM_VOICES-1:0] voice_wave,
  output logic [LVL_W-1:0]      mix_level,
  output logic                  pwm_out,
  output logic                  any_active
);

  logic [NUM_VOICES-1:0] hp_nz;
  logic [LVL_W-1:0]      pop;
  logic [LVL_W-1:0]      pwm_cnt;
  logic [LVL_W-1:0]      lvl_lat;
  logic [LVL_W-1:0]      lvl_now;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    tone_voice #(
      .HP_W(FREQ_W)
    ) u_voice (
      .clk    (clk),
      .reset_n(reset_n),
      .hp_in  (noteFrequency[g]),
      .wave   (voice_wave[g]),
      .active (hp_nz[g])
    );
  end

  assign any_active = |hp_nz;

  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      pop = pop + LVL_W'(voice_wave[i]);
    end
  end

  // Level in force for the current PWM period: on the first count of a
  // period the freshly latched mix applies, so every pulse of a period is
  // generated from one level and never changes width mid-period.
  assign lvl_now = (pwm_cnt == '0) ? mix_level : lvl_lat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mix_level <= '0;
      pwm_cnt   <= '0;
      lvl_lat   <= '0;
      pwm_out   <= 1'b0;
    end else begin
      mix_level <= pop;
      pwm_cnt   <= (pwm_cnt == LVL_W'(NUM_VOICES - 1)) ? '0 : pwm_cnt + LVL_W'(1);
      if (pwm_cnt == '0) begin
        lvl_lat <= mix_level;
      end
      pwm_out   <= (pwm_cnt < lvl_now);
    end
  end

endmodule
